// File: rtl/pump_valve_sequencer.sv
// Six-phase air-line sequencer for a three-valve peristaltic pump.
// Programmable dwell, stroke count or continuous run, direction, graceful stop.
module pump_valve_sequencer #(
  parameter int PHASE_W  = 16,
  parameter int STROKE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic [PHASE_W-1:0]  phase_len,
  input  logic [STROKE_W-1:0] stroke_req,
  output logic                air_valve1,
  output logic                air_dc,
  output logic                air_valve2,
  output logic                busy,
  output logic                done,
  output logic [STROKE_W-1:0] stroke_cnt
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, P4, P5} state_e;

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [PHASE_W-1:0]  len_q, len_d;
  logic [STROKE_W-1:0] req_q, req_d;
  logic                stop_q, stop_d;
  logic [PHASE_W-1:0]  dwell_q, dwell_d;
  logic [STROKE_W-1:0] cnt_q, cnt_d;
  logic [2:0]          air_q, air_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phase_end;

  // Reverse direction mirrors the pattern by swapping the two valve lines.
  function automatic logic [2:0] pattern(input state_e s, input logic rev);
    logic [2:0] f;
    case (s)
      P0:      f = 3'b011;
      P1:      f = 3'b001;
      P2:      f = 3'b101;
      P3:      f = 3'b100;
      P4:      f = 3'b110;
      default: f = 3'b111;
    endcase
    return rev ? {f[0], f[1], f[2]} : f;
  endfunction

  assign phase_end = (dwell_q == len_q - PHASE_W'(1));

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    len_d   = len_q;
    req_d   = req_q;
    stop_d  = stop_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = P0;
          dir_d   = dir;
          len_d   = (phase_len == '0) ? PHASE_W'(1) : phase_len;
          req_d   = stroke_req;
          stop_d  = stop;
          dwell_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        if (stop) stop_d = 1'b1;
        if (!phase_end) begin
          dwell_d = dwell_q + PHASE_W'(1);
        end else begin
          dwell_d = '0;
          case (state_q)
            P0: state_d = P1;
            P1: state_d = P2;
            P2: state_d = P3;
            P3: state_d = P4;
            P4: state_d = P5;
            default: begin
              cnt_d = cnt_q + STROKE_W'(1);
              // Stop in the final cycle of P5 still ends the run at this boundary.
              if (stop_q || stop || (req_q != '0 && cnt_d == req_q)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = P0;
              end
            end
          endcase
        end
      end
    endcase
    busy_d = (state_d != IDLE);
    air_d  = pattern(state_d, dir_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      len_q   <= PHASE_W'(1);
      req_q   <= '0;
      stop_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
      air_q   <= 3'b111;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      len_q   <= len_d;
      req_q   <= req_d;
      stop_q  <= stop_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      air_q   <= air_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign air_valve1 = air_q[2];
  assign air_dc     = air_q[1];
  assign air_valve2 = air_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign stroke_cnt = cnt_q;

endmodule
